// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a DEPTH-entry fetch buffer
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect yields one flagged NOP, then fetch halts.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misaligned
);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  logic [31:0]   pc_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic        deq, fetch_en, enq, stall, mis_enq;
  logic [31:0] load_pc, enq_instr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q, pend_q;
  logic mis_mem [DEPTH];

  // pend_q marks the cycle after a misaligned redirect, when the flagged NOP is queued.
  assign stall          = halt_q | pend_q;
  assign mis_enq        = pend_q & ~redirect_valid;
  assign load_pc        = redirect_pc;
  assign out_misaligned = mis_mem[rd_ptr_q];
`else
  assign stall          = 1'b0;
  assign mis_enq        = 1'b0;
  assign load_pc        = redirect_pc & ~32'h0000_0003;
  assign out_misaligned = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem[rd_ptr_q];
  assign out_instr = instr_mem[rd_ptr_q];

  assign deq       = out_valid & out_ready;
  assign fetch_en  = ~stall & ~redirect_valid & ((count_q != FULL) | deq);
  assign enq       = fetch_en | mis_enq;
  assign enq_instr = mis_enq ? NOP : imem_rdata;

  always_comb begin
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_q   <= 1'b0;
      pend_q   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_q     <= load_pc;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_q   <= 1'b0;
      pend_q   <= |redirect_pc[1:0];
`endif
    end else begin
      if (fetch_en) pc_q <= pc_q + 32'd4;
      if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (mis_enq) begin
        pend_q <= 1'b0;
        halt_q <= 1'b1;
      end
`endif
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= enq_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_mem[wr_ptr_q]   <= mis_enq;
`endif
    end
  end

endmodule
